regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_scoreboard.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and requester encoding for the writeback arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int RF_XLEN   = 32;
    localparam int RF_NREG   = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LSU  = 2'd1,
        REQ_MDU  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: tracks long-latency destinations, flags double marks, answers operand busy queries.
// Latency: mark/clear take effect on the next edge; busy lookup is combinational.
// Backpressure: none; marks and clears are always absorbed.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREG = RF_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mark_valid,
    input  logic [REG_IDX_W-1:0] mark_rd,
    input  logic                 clr_valid,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 sb_conflict
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic            mark_hit;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (mark_valid && (mark_rd != '0)) begin
            set_vec[mark_rd] = 1'b1;
        end
        if (clr_valid) begin
            clr_vec[clr_rd] = 1'b1;
        end
    end

    // A mark that lands on a bit being retired this cycle is a legal reuse, not a conflict.
    assign mark_hit = |(set_vec & pending & ~clr_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            sb_conflict <= 1'b0;
        end else begin
            pending <= set_vec | (pending & ~clr_vec);
            if (mark_hit) begin
                sb_conflict <= 1'b1;
            end
        end
    end

    // The regfile bypasses the value being written, so that register is not busy this cycle.
    assign rs1_busy = (q_rs1 != '0) && pending[q_rs1] && !(clr_valid && (clr_rd == q_rs1));
    assign rs2_busy = (q_rs2 != '0) && pending[q_rs2] && !(clr_valid && (clr_rd == q_rs2));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/LSU/MDU writebacks onto one regfile write port and hosts the scoreboard.
// Latency: accepted request appears on reg_write/wr_rd/wr_result one cycle later.
// Backpressure: one grant per cycle; ALU first, LSU/MDU round-robin, starvation guard after 3 waits.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 lsu_ready,
    input  logic                 mdu_valid,
    input  logic [REG_IDX_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]      mdu_data,
    output logic                 mdu_ready,
    input  logic                 mark_valid,
    input  logic [REG_IDX_W-1:0] mark_rd,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] wr_rd,
    output logic [XLEN-1:0]      wr_result,
    output logic                 sb_conflict
);

    localparam logic [1:0] WAIT_MAX = 2'd3;

    req_id_t              grant;
    logic                 last_winner;
    logic [1:0]           lsu_wait;
    logic [1:0]           mdu_wait;
    logic                 wr_vld_q;
    logic [REG_IDX_W-1:0] grant_rd;
    logic [XLEN-1:0]      grant_dat;

    always_comb begin
        grant = REQ_NONE;
        if (!rst) begin
            if (lsu_valid && (lsu_wait == WAIT_MAX)) begin
                grant = REQ_LSU;
            end else if (mdu_valid && (mdu_wait == WAIT_MAX)) begin
                grant = REQ_MDU;
            end else if (alu_valid) begin
                grant = REQ_ALU;
            end else if (lsu_valid && mdu_valid) begin
                grant = last_winner ? REQ_LSU : REQ_MDU;
            end else if (lsu_valid) begin
                grant = REQ_LSU;
            end else if (mdu_valid) begin
                grant = REQ_MDU;
            end
        end
    end

    assign alu_ready = (grant == REQ_ALU);
    assign lsu_ready = (grant == REQ_LSU);
    assign mdu_ready = (grant == REQ_MDU);

    always_comb begin
        grant_rd  = '0;
        grant_dat = '0;
        case (grant)
            REQ_ALU: begin
                grant_rd  = alu_rd;
                grant_dat = alu_data;
            end
            REQ_LSU: begin
                grant_rd  = lsu_rd;
                grant_dat = lsu_data;
            end
            REQ_MDU: begin
                grant_rd  = mdu_rd;
                grant_dat = mdu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q    <= 1'b0;
            wr_rd       <= '0;
            wr_result   <= '0;
            last_winner <= 1'b1;
            lsu_wait    <= '0;
            mdu_wait    <= '0;
        end else begin
            // Writes to x0 are consumed but never reach the regfile.
            wr_vld_q <= (grant != REQ_NONE) && (grant_rd != '0);
            if (grant != REQ_NONE) begin
                wr_rd     <= grant_rd;
                wr_result <= grant_dat;
            end
            if (lsu_ready) begin
                lsu_wait    <= '0;
                last_winner <= 1'b0;
            end else if (lsu_valid && (lsu_wait != WAIT_MAX)) begin
                lsu_wait <= lsu_wait + 2'd1;
            end
            if (mdu_ready) begin
                mdu_wait    <= '0;
                last_winner <= 1'b1;
            end else if (mdu_valid && (mdu_wait != WAIT_MAX)) begin
                mdu_wait <= mdu_wait + 2'd1;
            end
        end
    end

    // A result still in flight when reset arrives is dropped rather than written.
    assign reg_write = wr_vld_q && !rst;

    wb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .mark_valid  (mark_valid),
        .mark_rd     (mark_rd),
        .clr_valid   (reg_write),
        .clr_rd      (wr_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .sb_conflict (sb_conflict)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against an in-bench model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, mdu_valid, mark_valid;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd, mark_rd, q_rs1, q_rs2;
    logic [31:0] alu_data, lsu_data, mdu_data;
    logic        alu_ready, lsu_ready, mdu_ready;
    logic        rs1_busy, rs2_busy, reg_write, sb_conflict;
    logic [4:0]  wr_rd;
    logic [31:0] wr_result;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_write(reg_write), .wr_rd(wr_rd), .wr_result(wr_result), .sb_conflict(sb_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state after the most recent clock edge.
    bit          m_pend[32];
    bit          m_conf = 1'b0;
    int          m_last = 1;
    int          m_lw   = 0;
    int          m_mw   = 0;
    bit          m_rw   = 1'b0;
    int          m_wrrd = 0;
    logic [31:0] m_wrres = '0;
    bit          acc_alu, acc_lsu, acc_mdu;

    always @(negedge clk) begin : model_cmp
        int g;
        int rd;
        logic [31:0] dat;
        bit rw, b1, b2;
        g = -1;
        if (!rst) begin
            if (lsu_valid && m_lw >= 3)       g = 1;
            else if (mdu_valid && m_mw >= 3)  g = 2;
            else if (alu_valid)               g = 0;
            else if (lsu_valid && mdu_valid)  g = (m_last == 1) ? 1 : 2;
            else if (lsu_valid)               g = 1;
            else if (mdu_valid)               g = 2;
        end
        rw = m_rw && !rst;
        b1 = (q_rs1 != 0) && m_pend[q_rs1] && !(rw && m_wrrd == q_rs1);
        b2 = (q_rs2 != 0) && m_pend[q_rs2] && !(rw && m_wrrd == q_rs2);
        chk("alu_ready", alu_ready, g == 0);
        chk("lsu_ready", lsu_ready, g == 1);
        chk("mdu_ready", mdu_ready, g == 2);
        chk("reg_write", reg_write, rw);
        if (rw) begin
            chk("wr_rd", wr_rd, m_wrrd);
            chk("wr_result", wr_result, m_wrres);
        end
        chk("rs1_busy", rs1_busy, b1);
        chk("rs2_busy", rs2_busy, b2);
        chk("sb_conflict", sb_conflict, m_conf);
        acc_alu = (g == 0);
        acc_lsu = (g == 1);
        acc_mdu = (g == 2);

        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_conf = 0; m_last = 1; m_lw = 0; m_mw = 0;
            m_rw = 0; m_wrrd = 0; m_wrres = '0;
        end else begin
            if (mark_valid && mark_rd != 0 && m_pend[mark_rd] && !(rw && m_wrrd == mark_rd))
                m_conf = 1;
            if (rw) m_pend[m_wrrd] = 1'b0;
            if (mark_valid && mark_rd != 0) m_pend[mark_rd] = 1'b1;

            if (g == 1) begin m_lw = 0; m_last = 0; end
            else if (lsu_valid && m_lw < 3) m_lw++;
            if (g == 2) begin m_mw = 0; m_last = 1; end
            else if (mdu_valid && m_mw < 3) m_mw++;

            if (g >= 0) begin
                rd  = (g == 0) ? int'(alu_rd)   : (g == 1) ? int'(lsu_rd)   : int'(mdu_rd);
                dat = (g == 0) ? alu_data : (g == 1) ? lsu_data : mdu_data;
                m_rw = (rd != 0); m_wrrd = rd; m_wrres = dat;
            end else begin
                m_rw = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the caller just after the first non-reset edge's setup point.
    task automatic do_reset();
        cyc();
        rst = 1'b1;
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0; mark_valid = 0;
        cyc();
        rst = 1'b0;
    endtask

    int rr_exp[4] = '{1, 2, 1, 2};

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hdead;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        mark_valid = 0; mark_rd = 0; q_rs1 = 0; q_rs2 = 0;
        repeat (2) cyc();
        smp();
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wr_rd", wr_rd, 0);
        chk("rst_wr_result", wr_result, 0);
        chk("rst_conflict", sb_conflict, 0);
        chk("rst_alu_ready", alu_ready, 0);

        // ALU beats LSU; LSU follows one cycle later.
        cyc(); rst = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h22;
        smp();
        chk("pri_alu_ready", alu_ready, 1);
        chk("pri_lsu_ready", lsu_ready, 0);
        cyc(); alu_valid = 0; smp();
        chk("pri_wr1_en", reg_write, 1);
        chk("pri_wr1_rd", wr_rd, 5);
        chk("pri_wr1_dat", wr_result, 32'h11);
        chk("pri_lsu_ready2", lsu_ready, 1);
        cyc(); lsu_valid = 0; smp();
        chk("pri_wr2_en", reg_write, 1);
        chk("pri_wr2_rd", wr_rd, 6);
        chk("pri_wr2_dat", wr_result, 32'h22);

        // Round-robin between LSU and MDU after reset.
        do_reset();
        lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h80;
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h90;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            smp();
            chk("rr_lsu", lsu_ready, rr_exp[k] == 1);
            chk("rr_mdu", mdu_ready, rr_exp[k] == 2);
        end
        cyc(); mdu_valid = 0; smp();
        chk("rr_tail_lsu", lsu_ready, 1);
        cyc(); lsu_valid = 0;

        // Starvation guard lets LSU past a saturating ALU on its 4th waiting cycle.
        do_reset();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h5;
        lsu_valid = 1; lsu_rd = 10; lsu_data = 32'ha0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            smp();
            chk("stv_alu", alu_ready, k < 3);
            chk("stv_lsu", lsu_ready, k == 3);
        end
        cyc(); lsu_valid = 0; smp();
        chk("stv_wr_rd", wr_rd, 10);
        chk("stv_wr_dat", wr_result, 32'ha0);
        chk("stv_alu_back", alu_ready, 1);
        cyc(); alu_valid = 0;

        // Scoreboard mark, busy, clear with bypass.
        do_reset();
        mark_valid = 1; mark_rd = 7; q_rs1 = 7; q_rs2 = 0;
        smp(); chk("sb_busy_pre", rs1_busy, 0);
        cyc(); mark_valid = 0; smp();
        chk("sb_busy_set", rs1_busy, 1);
        cyc(); mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h77; smp();
        chk("sb_mdu_ready", mdu_ready, 1);
        chk("sb_busy_hold", rs1_busy, 1);
        cyc(); mdu_valid = 0; smp();
        chk("sb_wr_rd", wr_rd, 7);
        chk("sb_busy_bypass", rs1_busy, 0);
        cyc(); smp();
        chk("sb_busy_clear", rs1_busy, 0);

        // x0 marks are ignored; double mark of x7 is sticky until reset.
        do_reset();
        mark_valid = 1; mark_rd = 0; q_rs1 = 0;
        cyc(); cyc(); mark_valid = 0; smp();
        chk("x0_conflict", sb_conflict, 0);
        chk("x0_busy", rs1_busy, 0);
        cyc(); mark_valid = 1; mark_rd = 7; q_rs1 = 7;
        cyc(); smp();
        chk("dbl_conf_pre", sb_conflict, 0);
        cyc(); mark_valid = 0; smp();
        chk("dbl_conf_set", sb_conflict, 1);
        repeat (3) cyc();
        smp();
        chk("dbl_conf_sticky", sb_conflict, 1);
        do_reset(); smp();
        chk("dbl_conf_rst", sb_conflict, 0);

        // Reset right after an ALU acceptance drops the in-flight write.
        cyc(); mark_valid = 1; mark_rd = 4; q_rs1 = 4;
        cyc(); mark_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h33; smp();
        chk("rw_alu_ready", alu_ready, 1);
        chk("rw_busy_pre", rs1_busy, 1);
        cyc(); rst = 1; alu_rd = 2; lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hc0; smp();
        chk("rw_rst_reg_write", reg_write, 0);
        chk("rw_rst_alu_ready", alu_ready, 0);
        chk("rw_rst_lsu_ready", lsu_ready, 0);
        cyc(); rst = 0; alu_valid = 0; smp();
        chk("rw_post_reg_write", reg_write, 0);
        chk("rw_post_busy", rs1_busy, 0);
        chk("rw_post_lsu_ready", lsu_ready, 1);
        cyc(); lsu_valid = 0;

        // Randomized traffic, checked every cycle by the model.
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                if (!alu_valid || acc_alu) begin
                    alu_valid = ($urandom_range(0, 1) == 1);
                    alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
                end
                if (!lsu_valid || acc_lsu) begin
                    lsu_valid = ($urandom_range(0, 1) == 1);
                    lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
                end
                if (!mdu_valid || acc_mdu) begin
                    mdu_valid = ($urandom_range(0, 1) == 1);
                    mdu_rd = 5'($urandom_range(0, 31)); mdu_data = $urandom;
                end
                mark_valid = ($urandom_range(0, 7) == 0);
                mark_rd = 5'($urandom_range(0, 31));
                q_rs1 = 5'($urandom_range(0, 31));
                q_rs2 = 5'($urandom_range(0, 31));
                smp();
                cyc();
            end
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
